// File: rtl/sr_latch_driver.sv
// Command side of a NAND SR latch: turns set/clear requests into active-low drive pulses, then confirms the latch state through a synchronized readback.
// Latency: drive goes low 1 cycle after acceptance; done/err arrive in RESP. Requests are not accepted while busy.
// Optional SR_LATCH_DRIVER_SKIP_MATCH_EN: a request that matches the current readback skips the pulse and completes at once.
module sr_latch_driver #(
    parameter int PULSE_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int VERIFY_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       sbar,
    output logic       rbar,
    input  logic       q_in,
    input  logic       qbar_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] state
);

    localparam int CNT_MAX = (PULSE_CYCLES > VERIFY_TIMEOUT) ? PULSE_CYCLES : VERIFY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] VERIFY_LAST = CW'(VERIFY_TIMEOUT);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        VERIFY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 cur, nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
    logic                   target, target_nxt;
    logic                   done_nxt, err_nxt;
    logic [SYNC_STAGES-1:0] q_sync, qbar_sync;
    logic                   q_s, qbar_s, match;

    assign q_s    = q_sync[SYNC_STAGES-1];
    assign qbar_s = qbar_sync[SYNC_STAGES-1];
    // A latch showing q==qbar (both high) never counts as a match.
    assign match   = (q_s == target) && (qbar_s == ~target);
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

    always_comb begin
        nxt        = cur;
        cnt_nxt    = cnt_inc;
        target_nxt = target;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (cur)
            IDLE: begin
                cnt_nxt = '0;
                if (set_req && clr_req) begin
                    err_nxt = 1'b1;
                end else if (set_req ^ clr_req) begin
                    target_nxt = set_req;
`ifdef SR_LATCH_DRIVER_SKIP_MATCH_EN
                    if ((q_s == set_req) && (qbar_s == ~set_req)) begin
                        nxt      = RESP;
                        done_nxt = 1'b1;
                    end else begin
                        nxt = PULSE;
                    end
`else
                    nxt = PULSE;
`endif
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) nxt = VERIFY;
            end
            VERIFY: begin
                // cnt_inc is this cycle's position in the 1..VERIFY_TIMEOUT window.
                if (match) begin
                    nxt      = RESP;
                    done_nxt = 1'b1;
                end else if (cnt_inc == VERIFY_LAST) begin
                    nxt     = RESP;
                    err_nxt = 1'b1;
                end
            end
            RESP: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase
        if (nxt != cur) cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= IDLE;
            cnt       <= '0;
            target    <= 1'b0;
            q_sync    <= '0;
            qbar_sync <= '0;
            sbar      <= 1'b1;
            rbar      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            target    <= target_nxt;
            q_sync    <= {q_sync[SYNC_STAGES-2:0], q_in};
            qbar_sync <= {qbar_sync[SYNC_STAGES-2:0], qbar_in};
            // Drives decode from one next-state term, so both can never be low together.
            sbar      <= ~((nxt == PULSE) && target_nxt);
            rbar      <= ~((nxt == PULSE) && !target_nxt);
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    assign busy  = (cur != IDLE);
    assign state = cur;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: NAND-pair latch model, cycle-timeline reference model, directed vectors.
module tb_sr_latch_driver;

    localparam int P = 2;
    localparam int V = 4;

    logic       clk = 1'b0;
    logic       reset, set_req, clr_req;
    logic       sbar, rbar, q_in, qbar_in, busy, done, err;
    logic [1:0] state;

    int checks = 0;
    int passes = 0;

    sr_latch_driver #(.PULSE_CYCLES(P), .SYNC_STAGES(2), .VERIFY_TIMEOUT(V)) dut (
        .clk(clk), .reset(reset), .set_req(set_req), .clr_req(clr_req),
        .sbar(sbar), .rbar(rbar), .q_in(q_in), .qbar_in(qbar_in),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // NAND SR latch: a low on sbar sets, a low on rbar clears; stuck forces q readback low.
    logic lq    = 1'b0;
    logic stuck = 1'b0;
    always @(sbar or rbar) begin
        if (sbar === 1'b0 && rbar === 1'b1) lq = 1'b1;
        else if (sbar === 1'b1 && rbar === 1'b0) lq = 1'b0;
    end
    assign q_in    = stuck ? 1'b0 : lq;
    assign qbar_in = ~lq;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passes++;
    endtask

    // Reference model: timeline relative to the acceptance edge.
    int cyc = 0;
    int e_start = 0;
    int resp_at = -1;
    bit active = 0, skipped = 0, tgt = 0;
    bit exp_done = 0, exp_err = 0;
    bit h1q = 0, h1b = 0, h2q = 0, h2b = 0;
    bit model_valid = 0;

    always @(posedge clk) begin
        bit mq, mb, ok;
        cyc++;
        mq = h2q;
        mb = h2b;
        if (reset) begin
            active = 0; exp_done = 0; exp_err = 0;
            h1q = 0; h1b = 0; h2q = 0; h2b = 0;
            model_valid = 1;
        end else begin
            h2q = h1q; h2b = h1b; h1q = q_in; h1b = qbar_in;
            exp_done = 0; exp_err = 0;
            ok = (mq == tgt) && (mb != tgt);
            if (active) begin
                if (resp_at == cyc - 1) begin
                    active = 0;
                end else if (!skipped && (cyc - 1 - e_start) >= P) begin
                    if (ok) begin
                        exp_done = 1; resp_at = cyc;
                    end else if ((cyc - 1 - e_start) == P + V - 1) begin
                        exp_err = 1; resp_at = cyc;
                    end
                end
            end else if (set_req && clr_req) begin
                exp_err = 1;
            end else if (set_req ^ clr_req) begin
                tgt = set_req; active = 1; e_start = cyc; resp_at = -1; skipped = 0;
`ifdef SR_LATCH_DRIVER_SKIP_MATCH_EN
                if ((mq == tgt) && (mb != tgt)) begin
                    skipped = 1; resp_at = cyc; exp_done = 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        bit pulsing;
        logic [1:0] es;
        if (model_valid) begin
            pulsing = active && !skipped && (cyc - e_start) < P;
            if (!active) es = 2'd0;
            else if (resp_at == cyc) es = 2'd3;
            else if (pulsing) es = 2'd1;
            else es = 2'd2;
            check("cycle", {1'b0, sbar, rbar, busy, done, err, state},
                  {1'b0, !(pulsing && tgt), !(pulsing && !tgt), active, exp_done, exp_err, es});
            check("drive_excl", {7'd0, (sbar | rbar) & !(done & err)}, 8'd1);
        end
    end

    task automatic req(input logic s, input logic c);
        set_req = s; clr_req = c;
        @(negedge clk);
        set_req = 0; clr_req = 0;
    endtask

    initial begin
        int n;
        int lows;
        reset = 1; set_req = 0; clr_req = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("reset_vals", {1'b0, sbar, rbar, busy, done, err, state}, 8'b0110_0000);

        // set from q=0
        req(1, 0);
        check("set_t1_sbar", {7'd0, sbar}, 8'd0);
        @(negedge clk); check("set_t2_sbar", {7'd0, sbar}, 8'd0);
        @(negedge clk); check("set_t3_sbar", {7'd0, sbar}, 8'd1);
        n = 0;
        repeat (4) begin @(negedge clk); n += done; end
        check("set_done_cnt", 8'(n), 8'd1);
        check("set_q", {7'd0, lq}, 8'd1);

        // clear from q=1
        lows = 0;
        req(0, 1);
        lows += !sbar;
        check("clr_t1_rbar", {7'd0, rbar}, 8'd0);
        @(negedge clk); lows += !sbar; check("clr_t2_rbar", {7'd0, rbar}, 8'd0);
        @(negedge clk); lows += !sbar; check("clr_t3_rbar", {7'd0, rbar}, 8'd1);
        n = 0;
        repeat (4) begin @(negedge clk); n += done; lows += !sbar; end
        check("clr_done_cnt", 8'(n), 8'd1);
        check("clr_sbar_lows", 8'(lows), 8'd0);
        check("clr_q", {7'd0, lq}, 8'd0);

        // conflicting request
        req(1, 1);
        check("conf_err", {5'd0, err, sbar, rbar}, 8'b0000_0111);
        check("conf_busy", {7'd0, busy}, 8'd0);
        @(negedge clk); check("conf_err_pulse", {7'd0, err}, 8'd0);

        // stuck readback -> timeout
        stuck = 1;
        req(1, 0);
        repeat (2) @(negedge clk);
        check("stuck_release", {7'd0, sbar}, 8'd1);
        n = 0;
        repeat (3) begin @(negedge clk); n += err + done; end
        check("stuck_early", 8'(n), 8'd0);
        @(negedge clk);
        check("stuck_err_t7", {6'd0, err, done}, 8'b0000_0010);
        stuck = 0;
        @(negedge clk);

        // reset during second pulse cycle
        req(1, 0);
        reset = 1;
        @(negedge clk);
        check("rst_mid_sbar", {7'd0, sbar}, 8'd1);
        @(negedge clk);
        check("rst_mid_state", {5'd0, busy, state}, 8'd0);
        reset = 0;
        @(negedge clk);
        req(0, 1);
        check("post_rst_rbar", {7'd0, rbar}, 8'd0);
        n = 0;
        repeat (6) begin @(negedge clk); n += done; end
        check("post_rst_done", 8'(n), 8'd1);
        check("post_rst_q", {7'd0, lq}, 8'd0);

`ifdef SR_LATCH_DRIVER_SKIP_MATCH_EN
        // clear while already clear: no pulse, immediate done
        lows = 0; n = 0;
        req(0, 1);
        n += done; lows += !rbar;
        repeat (2) begin @(negedge clk); n += done; lows += !rbar; end
        check("skip_done", 8'(n), 8'd1);
        check("skip_no_pulse", 8'(lows), 8'd0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
